// File: rtl/clk_step_pkg.sv
// Shared types and default sizing for the core-clock sequencer.
package clk_step_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP_HI = 3'd1,
        STEP_LO = 3'd2,
        AUTO_HI = 3'd3,
        AUTO_LO = 3'd4
    } clk_state_t;

    localparam int STEP_HALF_DEF = 4;
    localparam int DIV_WIDTH_DEF = 24;
    localparam int CNT_WIDTH_DEF = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Probe-bus control/status bundle between the probe mapping (master) and the sequencer (slave).
interface clk_step_ctrl_if
    import clk_step_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 clk_auto_en;
    logic                 clk_step;
    logic [DIV_WIDTH-1:0] div_value;
    logic                 count_clr;
    logic                 core_clk;
    logic                 core_clk_en;
    logic                 busy;
    logic                 step_overrun;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output clk_auto_en, clk_step, div_value, count_clr,
        input  core_clk, core_clk_en, busy, step_overrun, cycle_count
    );

    modport slave (
        input  clk_auto_en, clk_step, div_value, count_clr,
        output core_clk, core_clk_en, busy, step_overrun, cycle_count
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with an optional registered rising-edge pulse.
module sync_edge_det
    import clk_step_pkg::*;
#(
    parameter bit USE_EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_in};
        end
    end

    assign level = sync_q[1];

    generate
        if (USE_EDGE) begin : g_edge
            logic prev_q;
            logic rise_q;

            // The pulse itself is registered so downstream logic sees a clean one-cycle strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[1];
                    rise_q <= sync_q[1] & ~prev_q;
                end
            end

            assign rise = rise_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/clk_step_ctrl.sv
// Core-clock sequencer: single debug steps or a free-running divided clock, plus cycle counter.
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int STEP_HALF = STEP_HALF_DEF
) (
    input  logic           clk,
    input  logic           rst,
    clk_step_ctrl_if.slave bus
);

    localparam int HC_W = max_int(DIV_WIDTH, $clog2(STEP_HALF));
    localparam logic [HC_W-1:0] STEP_LOAD = HC_W'(STEP_HALF - 1);

    logic auto_lvl;
    logic step_rise;
    logic step_level_unused;
    logic auto_rise_unused;

    sync_edge_det #(.USE_EDGE(1'b1)) u_step_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.clk_step),
        .level    (step_level_unused),
        .rise     (step_rise)
    );

    sync_edge_det #(.USE_EDGE(1'b0)) u_auto_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.clk_auto_en),
        .level    (auto_lvl),
        .rise     (auto_rise_unused)
    );

    clk_state_t           state_q, state_d;
    logic [HC_W-1:0]      half_q, half_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ovr_set;
    logic                 en_d;
    logic                 core_clk_q, en_q, busy_q, ovr_q;
    logic [CNT_WIDTH-1:0] count_q;

    // div_value is only sampled at an AUTO_HI entry so a running period is never reshaped.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        div_d   = div_q;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (auto_lvl) begin
                    state_d = AUTO_HI;
                    div_d   = bus.div_value;
                    half_d  = HC_W'(bus.div_value);
                end else if (step_rise) begin
                    state_d = STEP_HI;
                    half_d  = STEP_LOAD;
                end
            end
            STEP_HI, STEP_LO: begin
                ovr_set = step_rise;
                if (half_q == '0) begin
                    state_d = (state_q == STEP_HI) ? STEP_LO : IDLE;
                    half_d  = STEP_LOAD;
                end else begin
                    half_d = half_q - HC_W'(1);
                end
            end
            AUTO_HI: begin
                if (half_q == '0) begin
                    state_d = AUTO_LO;
                    half_d  = HC_W'(div_q);
                end else begin
                    half_d = half_q - HC_W'(1);
                end
            end
            AUTO_LO: begin
                if (half_q == '0) begin
                    if (auto_lvl) begin
                        state_d = AUTO_HI;
                        div_d   = bus.div_value;
                        half_d  = HC_W'(bus.div_value);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    half_d = half_q - HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        en_d = ((state_d == STEP_HI) && (state_q != STEP_HI)) ||
               ((state_d == AUTO_HI) && (state_q != AUTO_HI));
    end

    // Outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            half_q     <= '0;
            div_q      <= '0;
            core_clk_q <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            div_q      <= div_d;
            core_clk_q <= (state_d == STEP_HI) || (state_d == AUTO_HI);
            en_q       <= en_d;
            busy_q     <= (state_d != IDLE);
            ovr_q      <= ovr_q | ovr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.count_clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_WIDTH'(en_q);
        end
    end

    assign bus.core_clk     = core_clk_q;
    assign bus.core_clk_en  = en_q;
    assign bus.busy         = busy_q;
    assign bus.step_overrun = ovr_q;
    assign bus.cycle_count  = count_q;

endmodule
